// File: rtl/scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// scan_ctrl_pkg
// Shared definitions for the scan chain controller:
//   - scan_state_e : controller FSM state encodings
//   - OP_DUMP/OP_LOAD : host command op codes
//   - CNT_W / DATA_W : bit-counter and host data widths
// -----------------------------------------------------------------------------
package scan_ctrl_pkg;

  // Controller FSM states; encodings are fixed so they can be probed externally.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StResp  = 2'd2
  } scan_state_e;

  // Host command op codes.
  localparam logic OP_DUMP = 1'b0;  // non-destructive read
  localparam logic OP_LOAD = 1'b1;  // write new chain contents

  // Bit counter width; large enough to reach CHAIN_LEN without wrapping.
  localparam int unsigned CNT_W = 6;

  // Host command / response word width.
  localparam int unsigned DATA_W = 32;

endpackage

// File: rtl/scan_bit_counter.sv
// -----------------------------------------------------------------------------
// scan_bit_counter
// Counts shift cycles of one scan operation and flags the last one.
//
// Ports:
//   i_clk    : clock, rising edge
//   i_reset  : synchronous active-high reset (count -> 0)
//   i_clr    : clear count to 0 (command accept)
//   i_en     : advance count by one (shift cycle)
//   o_done   : count == CHAIN_LEN-1, i.e. the current cycle is the final shift
// -----------------------------------------------------------------------------
module scan_bit_counter
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 32
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);

  localparam logic [CNT_W-1:0] LastCount = CNT_W'(CHAIN_LEN - 1);

  logic [CNT_W-1:0] r_count;

  // The counter is cleared on every accept and advanced at most CHAIN_LEN
  // times per operation, so with CHAIN_LEN <= 32 it tops out at 32 and never
  // wraps within an operation.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_done = (r_count == LastCount);

endmodule

// File: rtl/scan_ctrl.sv
// -----------------------------------------------------------------------------
// scan_ctrl
// Host-driven scan chain controller. A host command either dumps the chain
// (non-destructive: serial-out is recirculated into serial-in) or loads new
// contents; in both cases the chain contents present before the operation are
// captured and returned as a response word.
//
// Ports:
//   i_clk        : sole clock, rising edge
//   i_reset      : synchronous active-high reset; aborts any operation
//   i_cmd_valid  : host command request
//   o_cmd_ready  : controller idle and able to accept a command
//   i_cmd_op     : OP_DUMP / OP_LOAD
//   i_cmd_data   : LOAD value, bit 0 enters the chain first
//   o_rsp_valid  : response word available
//   i_rsp_ready  : host accepts response
//   o_rsp_data   : chain contents captured before the operation, zero-extended
//   o_scan_sen   : scan enable to the chain
//   o_scan_ce    : scan clock-enable to the chain
//   o_scan_sin   : serial data into the chain (enters at bit CHAIN_LEN-1)
//   i_scan_sout  : serial data out of the chain (chain bit 0)
//   o_dut_hold   : high whenever not idle; freezes the functional logic
// -----------------------------------------------------------------------------
module scan_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 32  // legal range 1..32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_op,
  input  logic [DATA_W-1:0] i_cmd_data,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_scan_sen,
  output logic              o_scan_ce,
  output logic              o_scan_sin,
  input  logic              i_scan_sout,
  output logic              o_dut_hold
);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  scan_state_e            r_state;
  scan_state_e            w_state_next;

  logic                   r_op;
  logic [DATA_W-1:0]      r_data;      // LOAD bits, shifted so bit 0 is the next to send
  logic [CHAIN_LEN-1:0]   r_cap;       // capture shift register
  logic [CHAIN_LEN-1:0]   w_cap_next;
  logic [DATA_W-1:0]      r_rsp_data;
  logic [DATA_W-1:0]      w_rsp_ext;

  logic                   w_accept;
  logic                   w_shift;
  logic                   w_done;

  // ---------------------------------------------------------------------------
  // Shift-cycle counter
  // ---------------------------------------------------------------------------
  scan_bit_counter #(
    .CHAIN_LEN (CHAIN_LEN)
  ) u_bit_counter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_accept),
    .i_en    (w_shift),
    .o_done  (w_done)
  );

  // ---------------------------------------------------------------------------
  // Capture path: the chain's bit 0 appears on sout first, so shifting right
  // with sout entering at the top leaves chain bit i in capture bit i after
  // CHAIN_LEN shifts.
  // ---------------------------------------------------------------------------
  if (CHAIN_LEN == 1) begin : g_cap_single
    assign w_cap_next = i_scan_sout;
  end else begin : g_cap_multi
    assign w_cap_next = {i_scan_sout, r_cap[CHAIN_LEN-1:1]};
  end

  // The final capture bit is folded in combinationally so the response word is
  // complete in the same edge that enters RESP.
  always_comb begin
    w_rsp_ext                 = '0;
    w_rsp_ext[CHAIN_LEN-1:0]  = w_cap_next;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_shift      = 1'b0;
    o_cmd_ready  = 1'b0;
    o_rsp_valid  = 1'b0;
    o_scan_sen   = 1'b0;
    o_scan_ce    = 1'b0;
    o_scan_sin   = 1'b0;
    o_dut_hold   = 1'b1;

    unique case (r_state)
      StIdle: begin
        o_cmd_ready = 1'b1;
        o_dut_hold  = 1'b0;
        if (i_cmd_valid) begin
          w_accept     = 1'b1;
          w_state_next = StShift;
        end
      end

      StShift: begin
        w_shift    = 1'b1;
        o_scan_sen = 1'b1;
        o_scan_ce  = 1'b1;
        // DUMP recirculates so the chain ends up unchanged after a full rotation.
        o_scan_sin = (r_op == OP_LOAD) ? r_data[0] : i_scan_sout;
        if (w_done) begin
          w_state_next = StResp;
        end
      end

      StResp: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          w_state_next = StIdle;
        end
      end

      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  assign o_rsp_data = r_rsp_data;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_op       <= OP_DUMP;
      r_data     <= '0;
      r_cap      <= '0;
      r_rsp_data <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_accept) begin
        r_op   <= i_cmd_op;
        r_data <= i_cmd_data;
      end else if (w_shift) begin
        r_data <= {1'b0, r_data[DATA_W-1:1]};
      end

      if (w_shift) begin
        r_cap <= w_cap_next;
      end

      if (w_shift && w_done) begin
        r_rsp_data <= w_rsp_ext;
      end
    end
  end

endmodule

// File: tb/tb_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scan_ctrl
// Self-checking bench for scan_ctrl. Two instances: CHAIN_LEN=32 (main) and
// CHAIN_LEN=8. Each drives a behavioural scan chain. Expected response words
// are pushed to a scoreboard queue when a command is issued and popped when
// the DUT presents its response.
// -----------------------------------------------------------------------------
module tb_scan_ctrl;
  import scan_ctrl_pkg::*;

  localparam int unsigned Len = 32;
  localparam int unsigned Len8 = 8;

  logic clk;
  logic rst;

  // Main instance signals
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        sen, ce, sin, sout, hold;

  // Small instance signals
  logic        s8_cmd_valid, s8_cmd_ready, s8_cmd_op;
  logic [31:0] s8_cmd_data;
  logic        s8_rsp_valid, s8_rsp_ready;
  logic [31:0] s8_rsp_data;
  logic        s8_sen, s8_ce, s8_sin, s8_sout, s8_hold;

  // Behavioural chains with a preload port
  logic [Len-1:0]  chain32;
  logic [Len8-1:0] chain8;
  logic            pl32, pl8;
  logic [Len-1:0]  pl32_val;
  logic [Len8-1:0] pl8_val;

  logic [31:0] exp_chain;
  logic [31:0] sb_q[$];

  int unsigned n_checks;
  int unsigned n_pass;

  scan_ctrl #(
    .CHAIN_LEN (Len)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_op    (cmd_op),
    .i_cmd_data  (cmd_data),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_scan_sen  (sen),
    .o_scan_ce   (ce),
    .o_scan_sin  (sin),
    .i_scan_sout (sout),
    .o_dut_hold  (hold)
  );

  scan_ctrl #(
    .CHAIN_LEN (Len8)
  ) dut8 (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_cmd_valid (s8_cmd_valid),
    .o_cmd_ready (s8_cmd_ready),
    .i_cmd_op    (s8_cmd_op),
    .i_cmd_data  (s8_cmd_data),
    .o_rsp_valid (s8_rsp_valid),
    .i_rsp_ready (s8_rsp_ready),
    .o_rsp_data  (s8_rsp_data),
    .o_scan_sen  (s8_sen),
    .o_scan_ce   (s8_ce),
    .o_scan_sin  (s8_sin),
    .i_scan_sout (s8_sout),
    .o_dut_hold  (s8_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl32) chain32 <= pl32_val;
    else if (sen && ce) chain32 <= {sin, chain32[Len-1:1]};
  end
  assign sout = chain32[0];

  always @(posedge clk) begin
    if (pl8) chain8 <= pl8_val;
    else if (s8_sen && s8_ce) chain8 <= {s8_sin, chain8[Len8-1:1]};
  end
  assign s8_sout = chain8[0];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  task automatic preload32(input logic [31:0] val);
    @(negedge clk);
    pl32 = 1'b1;
    pl32_val = val;
    @(negedge clk);
    pl32 = 1'b0;
    exp_chain = val;
  endtask

  task automatic sb_pop_check(input string tag, input logic [31:0] act);
    logic [31:0] exp_rsp;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      exp_rsp = sb_q.pop_front();
      check_eq(tag, act, exp_rsp);
    end
  endtask

  // Issue one command on the main instance and follow it through to IDLE.
  task automatic run_cmd(input logic op, input logic [31:0] data, input int hold_cycles);
    int n;
    int ce_cnt;
    int waited;
    logic [31:0] held;
    waited = 0;
    while (!cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check_eq("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    sb_q.push_back(exp_chain);
    if (op == OP_LOAD) exp_chain = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_data  = $urandom;
    n = 1;
    ce_cnt = 0;
    while (!rsp_valid && n < 200) begin
      if (ce && sen && hold && !cmd_ready) ce_cnt++;
      @(negedge clk);
      n++;
    end
    check_eq("rsp_latency", 32'(n), Len + 1);
    check_eq("shift_cycles", 32'(ce_cnt), Len);
    held = rsp_data;
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      check_eq("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("stall_rsp_data", rsp_data, held);
      check_eq("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check_eq("stall_scan_ce", {31'd0, ce}, 32'd0);
    end
    sb_pop_check("rsp_data", rsp_data);
    rsp_ready = 1'b1;
    check_eq("resp_no_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("idle_after_rsp", {29'd0, hold, rsp_valid, cmd_ready}, 32'd1);
    check_eq("chain_contents", chain32, exp_chain);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bursts;
    int nrsp;
    int p;
    int n;
    int ce_cnt;
    logic prev_ce;
    logic exp_sh;
    logic exp_rs;

    n_checks = 0;
    n_pass = 0;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = OP_DUMP; cmd_data = '0; rsp_ready = 1'b0;
    s8_cmd_valid = 1'b0; s8_cmd_op = OP_DUMP; s8_cmd_data = '0; s8_rsp_ready = 1'b0;
    pl32 = 1'b0; pl32_val = '0; pl8 = 1'b0; pl8_val = '0;
    exp_chain = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_data", rsp_data, 32'd0);
    check_eq("rst_scan", {29'd0, sen, ce, sin}, 32'd0);
    check_eq("rst_hold", {31'd0, hold}, 32'd0);
    check_eq("rst8_rsp_data", s8_rsp_data, 32'd0);
    rst = 1'b0;

    // Dump twice: non-destructive
    preload32(32'hDEADBEEF);
    run_cmd(OP_DUMP, 32'h0000_0000, 0);
    run_cmd(OP_DUMP, 32'hFFFF_FFFF, 0);

    // Load returns old contents; following dump with a stalled response
    preload32(32'h0000_0001);
    run_cmd(OP_LOAD, 32'hA5A5F00F, 0);
    run_cmd(OP_DUMP, 32'h0000_0000, 10);

    // Reset mid-LOAD at shift cycle 7, with a command also pending
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = 32'hCAFEF00D;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("abort_in_shift", {31'd0, ce}, 32'd1);
    rst = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    check_eq("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("abort_rsp", {31'd0, rsp_valid}, 32'd0);
    check_eq("abort_rsp_data", rsp_data, 32'd0);
    check_eq("abort_scan", {29'd0, sen, ce, sin}, 32'd0);
    check_eq("abort_hold", {31'd0, hold}, 32'd0);
    cmd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_idle", {30'd0, ce, cmd_ready}, 32'd1);
    // Chain contents are undefined after an abort; re-establish a known state.
    preload32(32'h0000_0000);
    run_cmd(OP_LOAD, 32'h12345678, 0);
    run_cmd(OP_DUMP, 32'h0000_0000, 2);

    // cmd_valid held high: accepts only in IDLE, period Len+2
    for (int r = 0; r < 3; r++) sb_q.push_back(exp_chain);
    cmd_valid = 1'b1; cmd_op = OP_DUMP; cmd_data = $urandom; rsp_ready = 1'b1;
    bursts = 0; nrsp = 0; prev_ce = 1'b0;
    for (int i = 1; i <= 3 * (Len + 2); i++) begin
      @(negedge clk);
      p = i % (Len + 2);
      exp_sh = (p >= 1) && (p <= Len);
      exp_rs = (p == Len + 1);
      check_eq("cont_ce", {31'd0, ce}, {31'd0, exp_sh});
      check_eq("cont_hold", {31'd0, hold}, {31'd0, exp_sh | exp_rs});
      check_eq("cont_ready", {31'd0, cmd_ready}, {31'd0, p == 0});
      if (ce && !prev_ce) bursts++;
      prev_ce = ce;
      if (rsp_valid) begin
        nrsp++;
        sb_pop_check("cont_rsp_data", rsp_data);
      end
      if (i == 3 * (Len + 2)) cmd_valid = 1'b0;
    end
    rsp_ready = 1'b0;
    check_eq("cont_bursts", 32'(bursts), 32'd3);
    check_eq("cont_rsps", 32'(nrsp), 32'd3);
    check_eq("cont_chain", chain32, exp_chain);

    // Short chain: CHAIN_LEN=8, DUMP of 0x5C
    @(negedge clk);
    pl8 = 1'b1; pl8_val = 8'h5C;
    @(negedge clk);
    pl8 = 1'b0;
    check_eq("s8_cmd_ready", {31'd0, s8_cmd_ready}, 32'd1);
    s8_cmd_valid = 1'b1; s8_cmd_op = OP_DUMP; s8_cmd_data = 32'hFFFF_FFFF;
    sb_q.push_back(32'h0000_005C);
    @(negedge clk);
    s8_cmd_valid = 1'b0;
    n = 1; ce_cnt = 0;
    while (!s8_rsp_valid && n < 200) begin
      if (s8_ce && s8_sen) ce_cnt++;
      @(negedge clk);
      n++;
    end
    check_eq("s8_latency", 32'(n), Len8 + 1);
    check_eq("s8_shift_cycles", 32'(ce_cnt), Len8);
    sb_pop_check("s8_rsp_data", s8_rsp_data);
    s8_rsp_ready = 1'b1;
    @(negedge clk);
    s8_rsp_ready = 1'b0;
    check_eq("s8_idle", {30'd0, s8_rsp_valid, s8_cmd_ready}, 32'd1);
    check_eq("s8_chain", {24'd0, chain8}, 32'h0000_005C);

    check_eq("sb_drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scan_ctrl.md
SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 Parameter CHAIN_LEN, default 32: scan chain length in bits; legal range 1..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  host command request.
REQ-005 cmd_ready  output  1  controller can accept a command.
REQ-006 cmd_op  input  1  0 = DUMP (non-destructive read), 1 = LOAD (write new chain contents).
REQ-007 cmd_data  input  32  LOAD value; bit 0 enters the chain first; ignored for DUMP.
REQ-008 rsp_valid  output  1  response word available.
REQ-009 rsp_ready  input  1  host accepts response.
REQ-010 rsp_data  output  32  chain contents captured before the operation; bits >= CHAIN_LEN read 0.
REQ-011 scan_sen  output  1  scan enable to chain.
REQ-012 scan_ce  output  1  scan clock-enable to chain.
REQ-013 scan_sin  output  1  serial data into chain.
REQ-014 scan_sout  input  1  serial data out of chain.
REQ-015 dut_hold  output  1  high whenever the controller is not IDLE; the owning wrapper gates functional reg_en with it.

Function
REQ-016 Chain model: scan_sout presents chain bit 0. Each cycle with scan_sen=1 and scan_ce=1, bit i takes bit i+1 and bit CHAIN_LEN-1 takes scan_sin.
REQ-017 FSM states are IDLE, SHIFT and RESP; reset enters IDLE.
REQ-018 cmd_ready=1 only in IDLE; a command is accepted on any cycle with cmd_valid and cmd_ready both high.
REQ-019 On accept: IDLE->SHIFT; register cmd_op and cmd_data; clear bit counter to 0.
REQ-020 In SHIFT: scan_sen=1 and scan_ce=1 for exactly CHAIN_LEN consecutive cycles; both are 0 in every other state.
REQ-021 SHIFT cycle k (k = 0..CHAIN_LEN-1), capture: the capture register shifts right and takes scan_sout into bit CHAIN_LEN-1 (the sout value before that edge).
REQ-022 SHIFT cycle k, scan_sin: DUMP drives scan_sin = scan_sout (combinational recirculate); LOAD drives scan_sin = registered cmd_data bit k.
REQ-023 On counter == CHAIN_LEN-1: SHIFT->RESP; rsp_data = captured word, zero-extended.
REQ-024 Latency: for accept at edge T, shift cycles are T+1..T+CHAIN_LEN and rsp_valid=1 from cycle T+CHAIN_LEN+1.
REQ-025 In RESP: rsp_valid stays 1 and rsp_data stays stable until rsp_ready=1; then RESP->IDLE and cmd_ready=1 on the following cycle (no same-cycle command acceptance).
REQ-026 After DUMP the chain holds its original value; after LOAD the chain holds cmd_data[CHAIN_LEN-1:0].
REQ-027 cmd_valid while not IDLE is ignored; cmd_* are don't-care outside the accept cycle.
REQ-028 Bit counter width is 6 bits; it never wraps within an operation.

Reset
REQ-029 Reset values: state IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, scan_sen=0, scan_ce=0, scan_sin=0, dut_hold=0, counter=0.
REQ-030 Reset asserted mid-SHIFT or mid-RESP aborts the operation immediately, with no further shifts and the response dropped; chain contents are then undefined.
REQ-031 Reset has priority over command accept in the same cycle.

Structure
REQ-032 A shared include file holds the state encodings (IDLE=2'd0, SHIFT=2'd1, RESP=2'd2) and the op codes OP_DUMP=1'b0 and OP_LOAD=1'b1.
REQ-033 One sub-module, scan_bit_counter, implements the 6-bit counter with clr, en and a done flag at CHAIN_LEN-1.

Verification
REQ-034 Chain preloaded with 0xDEADBEEF, DUMP -> rsp_valid at T+33, rsp_data=0xDEADBEEF, and a second DUMP again returns 0xDEADBEEF.
REQ-035 Chain holds 0x00000001, LOAD 0xA5A5F00F -> rsp_data=0x00000001, and a following DUMP returns 0xA5A5F00F.
REQ-036 rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, scan_ce=0 throughout.
REQ-037 Reset asserted at shift cycle 7 of a LOAD -> next cycle all outputs at reset values, and a subsequent LOAD 0x12345678 followed by DUMP returns 0x12345678.
REQ-038 CHAIN_LEN=8, chain=0x5C, DUMP -> exactly 8 scan_ce cycles, rsp_data=0x0000005C.
REQ-039 cmd_valid held high continuously -> commands accepted only in IDLE, one scan_ce burst per accept, dut_hold=1 exactly for SHIFT and RESP cycles.
